// File: rtl/reg_status_file.sv
// reg_status_file
//   Architectural register file with rename status for an out-of-order core.
//   Holds 32 x 32-bit values, a busy bit per register and the 4-bit ROB tag
//   of the youngest in-flight producer. Two combinational read ports include
//   a bypass from the retiring ROB entry, so a value committing this cycle
//   is visible at issue without waiting a cycle.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rdy                           global stall; low freezes all state
//   rs1_addr, rs2_addr            operand register numbers
//   rs1_busy/robnum/value         read port 1 (robnum valid when busy,
//                                 value valid when not busy)
//   rs2_busy/robnum/value         read port 2
//   issue_valid/rd/robnum         rename rd to a ROB entry
//   commit_valid/rd/robnum/data   ROB retirement write
//   flush                         misbranch: drop all speculative renames
module reg_status_file (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic        rs1_busy,
   output logic        rs2_busy,
   output logic [3:0]  rs1_robnum,
   output logic [3:0]  rs2_robnum,
   output logic [31:0] rs1_value,
   output logic [31:0] rs2_value,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic [3:0]  issue_robnum,
   input  logic        commit_valid,
   input  logic [4:0]  commit_rd,
   input  logic [3:0]  commit_robnum,
   input  logic [31:0] commit_data,
   input  logic        flush
);

   logic [31:0] value_q [32];
   logic [3:0]  tag_q   [32];
   logic [31:0] busy_q;

   logic commit_ok;
   logic issue_ok;
   logic rs1_bypass;
   logic rs2_bypass;

   // x0 is hardwired: neither rename nor retirement may touch it.
   assign commit_ok = commit_valid && (commit_rd != 5'd0);
   assign issue_ok  = issue_valid && (issue_rd != 5'd0) && !flush;

   // Bypass only when the retiring entry is the one the register still
   // waits on; a stale commit must not make a younger rename look ready.
   always_comb begin
      rs1_bypass = 1'b0;
      if (commit_ok && (commit_rd == rs1_addr) && busy_q[rs1_addr] &&
          (tag_q[rs1_addr] == commit_robnum))
         rs1_bypass = 1'b1;
   end

   always_comb begin
      rs2_bypass = 1'b0;
      if (commit_ok && (commit_rd == rs2_addr) && busy_q[rs2_addr] &&
          (tag_q[rs2_addr] == commit_robnum))
         rs2_bypass = 1'b1;
   end

   // Reads see registered state only (plus commit bypass), never this
   // cycle's issue, so "add x1,x1,x2" picks up the previous mapping of x1.
   always_comb begin
      rs1_busy   = 1'b0;
      rs1_robnum = 4'd0;
      rs1_value  = 32'd0;
      if (rs1_addr != 5'd0) begin
         rs1_busy   = busy_q[rs1_addr] && !rs1_bypass;
         rs1_robnum = tag_q[rs1_addr];
         rs1_value  = rs1_bypass ? commit_data : value_q[rs1_addr];
      end
   end

   always_comb begin
      rs2_busy   = 1'b0;
      rs2_robnum = 4'd0;
      rs2_value  = 32'd0;
      if (rs2_addr != 5'd0) begin
         rs2_busy   = busy_q[rs2_addr] && !rs2_bypass;
         rs2_robnum = tag_q[rs2_addr];
         rs2_value  = rs2_bypass ? commit_data : value_q[rs2_addr];
      end
   end

   // Update order within the block matters: commit first, then flush clears
   // every busy bit, then issue (skipped on flush) overrides the commit's
   // busy/tag effect when both target the same register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 32'd0;
         for (int i = 0; i < 32; i++) begin
            value_q[i] <= 32'd0;
            tag_q[i]   <= 4'd0;
         end
      end else if (rdy) begin
         if (commit_ok) begin
            value_q[commit_rd] <= commit_data;
            if (tag_q[commit_rd] == commit_robnum)
               busy_q[commit_rd] <= 1'b0;
         end
         if (flush)
            busy_q <= 32'd0;
         if (issue_ok) begin
            busy_q[issue_rd] <= 1'b1;
            tag_q[issue_rd]  <= issue_robnum;
         end
      end
   end

endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file
//   Directed bench for reg_status_file: rename/commit, stale commit,
//   same-cycle issue+commit, flush, x0 handling, stall and reset.
module tb_reg_status_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        rs1_busy, rs2_busy;
   logic [3:0]  rs1_robnum, rs2_robnum;
   logic [31:0] rs1_value, rs2_value;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [3:0]  issue_robnum;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [3:0]  commit_robnum;
   logic [31:0] commit_data;
   logic        flush;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   reg_status_file dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy),
      .rs1_robnum    (rs1_robnum),
      .rs2_robnum    (rs2_robnum),
      .rs1_value     (rs1_value),
      .rs2_value     (rs2_value),
      .issue_valid   (issue_valid),
      .issue_rd      (issue_rd),
      .issue_robnum  (issue_robnum),
      .commit_valid  (commit_valid),
      .commit_rd     (commit_rd),
      .commit_robnum (commit_robnum),
      .commit_data   (commit_data),
      .flush         (flush)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and return 1 time unit after it.
   task automatic cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      issue_valid   = 1'b0;
      issue_rd      = 5'd0;
      issue_robnum  = 4'd0;
      commit_valid  = 1'b0;
      commit_rd     = 5'd0;
      commit_robnum = 4'd0;
      commit_data   = 32'd0;
      flush         = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [3:0] rob);
      issue_valid  = 1'b1;
      issue_rd     = rd;
      issue_robnum = rob;
   endtask

   task automatic commit(input logic [4:0] rd, input logic [3:0] rob, input logic [31:0] data);
      commit_valid  = 1'b1;
      commit_rd     = rd;
      commit_robnum = rob;
      commit_data   = data;
   endtask

   // Point port 1 at a register and let the combinational read settle.
   task automatic look(input logic [4:0] r);
      rs1_addr = r;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      rs1_addr = 5'd0;
      rs2_addr = 5'd0;
      idle();
      cycle();
      cycle();
      rst = 1'b0;

      // Reset state
      rs2_addr = 5'd31;
      look(5'd5);
      check("rst_busy1", {31'd0, rs1_busy}, 32'd0);
      check("rst_value1", rs1_value, 32'd0);
      check("rst_busy2", {31'd0, rs2_busy}, 32'd0);
      check("rst_value2", rs2_value, 32'd0);

      // Rename then commit with bypass
      issue(5'd5, 4'd3);
      cycle();
      idle();
      look(5'd5);
      check("ren_busy", {31'd0, rs1_busy}, 32'd1);
      check("ren_robnum", {28'd0, rs1_robnum}, 32'd3);
      commit(5'd5, 4'd3, 32'hDEADBEEF);
      #1;
      check("byp_busy", {31'd0, rs1_busy}, 32'd0);
      check("byp_value", rs1_value, 32'hDEADBEEF);
      cycle();
      idle();
      look(5'd5);
      check("cmt_busy", {31'd0, rs1_busy}, 32'd0);
      check("cmt_value", rs1_value, 32'hDEADBEEF);

      // Read does not see same-cycle issue
      issue(5'd1, 4'd9);
      look(5'd1);
      check("sameiss_busy", {31'd0, rs1_busy}, 32'd0);
      cycle();
      idle();
      look(5'd1);
      check("sameiss_after", {31'd0, rs1_busy}, 32'd1);

      // Stale commit leaves younger rename busy
      issue(5'd7, 4'd2);
      cycle();
      issue(5'd7, 4'd6);
      cycle();
      idle();
      commit(5'd7, 4'd2, 32'h11);
      look(5'd7);
      check("stale_nobyp_busy", {31'd0, rs1_busy}, 32'd1);
      check("stale_nobyp_val", rs1_value, 32'd0);
      cycle();
      idle();
      look(5'd7);
      check("stale_busy", {31'd0, rs1_busy}, 32'd1);
      check("stale_robnum", {28'd0, rs1_robnum}, 32'd6);
      check("stale_value", rs1_value, 32'h11);
      commit(5'd7, 4'd6, 32'h22);
      #1;
      check("young_byp_busy", {31'd0, rs1_busy}, 32'd0);
      check("young_byp_val", rs1_value, 32'h22);
      cycle();
      idle();
      look(5'd7);
      check("young_busy", {31'd0, rs1_busy}, 32'd0);
      check("young_value", rs1_value, 32'h22);

      // Same-cycle issue and commit: issue wins busy/tag
      issue(5'd9, 4'd4);
      cycle();
      idle();
      commit(5'd9, 4'd4, 32'h55);
      issue(5'd9, 4'd8);
      cycle();
      idle();
      look(5'd9);
      check("sim_busy", {31'd0, rs1_busy}, 32'd1);
      check("sim_robnum", {28'd0, rs1_robnum}, 32'd8);
      check("sim_value", rs1_value, 32'h55);

      // Flush with coincident commit and issue
      for (int i = 1; i < 32; i++) begin
         issue(5'(i), 4'(i % 16));
         cycle();
      end
      idle();
      look(5'd20);
      check("fl_pre_busy", {31'd0, rs1_busy}, 32'd1);
      check("fl_pre_robnum", {28'd0, rs1_robnum}, 32'd4);
      flush = 1'b1;
      commit(5'd3, 4'd3, 32'h99);
      issue(5'd4, 4'd1);
      cycle();
      idle();
      for (int i = 1; i < 32; i++) begin
         look(5'(i));
         check($sformatf("fl_busy_x%0d", i), {31'd0, rs1_busy}, 32'd0);
      end
      look(5'd3);
      check("fl_x3_value", rs1_value, 32'h99);

      // x0 ignored
      issue(5'd0, 4'd5);
      commit(5'd0, 4'd5, 32'hFF);
      look(5'd0);
      check("x0_byp_value", rs1_value, 32'd0);
      cycle();
      idle();
      look(5'd0);
      check("x0_busy", {31'd0, rs1_busy}, 32'd0);
      check("x0_value", rs1_value, 32'd0);
      check("x0_robnum", {28'd0, rs1_robnum}, 32'd0);

      // Stall: no state change
      rdy = 1'b0;
      issue(5'd10, 4'd1);
      commit(5'd5, 4'd0, 32'h1234);
      cycle();
      idle();
      rdy = 1'b1;
      look(5'd10);
      check("stall_busy", {31'd0, rs1_busy}, 32'd0);
      look(5'd5);
      check("stall_value", rs1_value, 32'hDEADBEEF);

      // Reset mid-operation
      issue(5'd2, 4'd1);
      cycle();
      issue(5'd6, 4'd2);
      cycle();
      idle();
      look(5'd6);
      check("prerst_busy", {31'd0, rs1_busy}, 32'd1);
      rst = 1'b1;
      issue(5'd11, 4'd3);
      cycle();
      rst = 1'b0;
      idle();
      for (int i = 0; i < 32; i++) begin
         look(5'(i));
         check($sformatf("rst2_busy_x%0d", i), {31'd0, rs1_busy}, 32'd0);
         check($sformatf("rst2_val_x%0d", i), rs1_value, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_status_file.md
REG_STATUS_FILE -- requirements
Module: reg_status_file

Interface
REQ-001 SHALL have ports: clk input 1 (clock); rst input 1 (reset: synchronous, active-high).
REQ-002 SHALL have rdy input 1; when low, all state holds.
REQ-003 SHALL have rs1_addr and rs2_addr, each input 5, issue operand register numbers.
REQ-004 SHALL have rs1_busy, rs2_busy, each output 1: operand still pending in the ROB.
REQ-005 SHALL have rs1_robnum, rs2_robnum, each output 4: producing ROB entry, valid when busy.
REQ-006 SHALL have rs1_value, rs2_value, each output 32: architectural value, valid when not busy.
REQ-007 SHALL have issue_valid input 1, issue_rd input 5 and issue_robnum input 4: issued instruction renames rd to a ROB entry.
REQ-008 SHALL have commit_valid input 1, commit_rd input 5, commit_robnum input 4 and commit_data input 32: ROB retirement write.
REQ-009 SHALL have flush input 1: ROB misbranch, which cancels all speculative renames.

Function
REQ-010 SHALL hold 32 x 32-bit value registers, plus a 32-entry busy bit and a 32-entry 4-bit tag table.
REQ-011 SHALL provide read ports that are combinational from registered state plus the commit bypass (REQ-012); read latency is 0 cycles.
REQ-012 Bypass: if commit_valid, commit_rd equals rsN_addr (nonzero), and the entry is busy with tag equal to commit_robnum, then rsN_busy=0 and rsN_value=commit_data.
REQ-013 Reads SHALL NOT see the same-cycle issue write, so "add x1,x1,x2" gets the old x1 mapping.
REQ-014 x0: reads always return busy=0, value=0, robnum=0; issue or commit targeting x0 SHALL be ignored.
REQ-015 Commit, on the clock edge when rdy: value[commit_rd] <= commit_data, always (commit order = program order).
REQ-016 Commit SHALL clear busy[commit_rd] only if tag[commit_rd]==commit_robnum; otherwise a younger rename stays busy.
REQ-017 Issue, on the clock edge when rdy and issue_valid: busy[issue_rd] <= 1 and tag[issue_rd] <= issue_robnum.
REQ-018 Same-cycle issue and commit to the same rd: the value is written, and busy/tag take the issue result (issue wins).
REQ-019 Flush: all busy bits SHALL clear on that edge, and tags are don't-care.
REQ-020 A commit in the flush cycle SHALL still write its value, because ROB jalr commit and misbranch coincide.
REQ-021 Issue in the flush cycle SHALL be ignored, because it is on the wrong path.
REQ-022 When rdy is low: no state change, and read ports stay combinationally valid.
REQ-023 rsN_robnum SHALL output tag[rsN_addr] regardless of busy (don't-care when not busy).

Reset
REQ-024 On rst: all 32 values <= 0, all busy <= 0, all tags <= 0.
REQ-025 Reset SHALL take priority over flush, issue, commit and rdy.
REQ-026 After reset, all read outputs SHALL be busy=0 and value=0.

Verification
REQ-027 Rename/commit: issue x5->rob 3; next cycle read x5 -> busy=1, robnum=3; commit x5 rob3 data 0xDEADBEEF -> same-cycle read busy=0, value=0xDEADBEEF; after the edge, registered busy=0.
REQ-028 Stale commit: issue x7->rob2, then issue x7->rob6, then commit x7 rob2 data 0x11 -> x7 busy=1, robnum=6, value reg=0x11; then commit x7 rob6 data 0x22 -> busy=0, value=0x22.
REQ-029 Simultaneous issue and commit: x9 busy with tag 4; in one cycle commit x9 rob4 data 0x55 and issue x9->rob8 -> after the edge busy=1, robnum=8, value reg=0x55.
REQ-030 Flush: rename x1..x31 to various tags, then in one cycle flush with commit x3 data 0x99 and issue x4->rob1 -> all busy=0, x3=0x99, x4 not renamed.
REQ-031 x0 and rdy: issue x0->rob5 and commit x0 data 0xFF -> x0 reads busy=0, value=0; with rdy=0, issue x10->rob1 -> x10 stays not busy.
REQ-032 Reset mid-operation: with several regs busy and values nonzero, assert rst with issue_valid=1 -> next cycle all busy=0, all values=0.
